// File: rtl/demux_channel_buffer_pkg.sv
// Shared constants and types for the demux channel buffer.
// Defaults match the upstream 8-bit, 8-channel demux.
package demux_buf_pkg;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SEL_W-1:0]  ch_t;

endpackage

// File: rtl/demux_channel_buffer_if.sv
// Input handshake plus per-channel output streams.
// master = upstream/consumers, slave = the buffer.
interface demux_channel_buffer_if
  import demux_buf_pkg::*;
#(
  parameter int DW = demux_buf_pkg::DATA_W,
  parameter int NC = demux_buf_pkg::NUM_CH,
  parameter int SW = demux_buf_pkg::SEL_W
);

  logic             in_valid;
  logic             in_ready;
  logic [SW-1:0]    in_sel;
  logic [DW-1:0]    in_data;
  logic [NC-1:0]    out_valid;
  logic [NC-1:0]    out_ready;
  logic [NC*DW-1:0] out_data;
  logic [NC-1:0]    ch_full;
  logic             drop_pulse;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, ch_full, drop_pulse
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, ch_full, drop_pulse
  );

endinterface

// File: rtl/demux_channel_buffer_ch_fifo.sv
// Single-channel first-word-fall-through FIFO.
// Head byte comes straight from registered storage.
module ch_fifo
  import demux_buf_pkg::*;
#(
  parameter int DW = demux_buf_pkg::DATA_W,
  parameter int DP = demux_buf_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          full_o
);

  localparam int PW = $clog2(DP);

  logic [DW-1:0] mem_q [DP];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == (PW+1)'(DP));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & valid_o;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;

  // Next pointers and occupancy; pointers wrap naturally.
  always_comb begin
    wr_d  = do_push ? wr_q + PW'(1) : wr_q;
    rd_d  = do_pop  ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers; reset empties the channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write; stale contents are masked by valid_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/demux_channel_buffer.sv
// Steers one byte per cycle into per-channel FIFOs.
// Selects beyond the channel count are accepted and dropped.
module demux_channel_buffer
  import demux_buf_pkg::*;
#(
  parameter int DATA_W = demux_buf_pkg::DATA_W,
  parameter int NUM_CH = demux_buf_pkg::NUM_CH,
  parameter int SEL_W  = demux_buf_pkg::SEL_W,
  parameter int DEPTH  = demux_buf_pkg::DEPTH
) (
  input logic clk,
  input logic rst,
  demux_channel_buffer_if.slave bus
);

  localparam int NSEL = 2**SEL_W;

  logic [NSEL-1:0]   full_pad;
  logic [NUM_CH-1:0] full_v;
  logic [NUM_CH-1:0] valid_v;
  logic [NUM_CH-1:0] push_v;
  logic [DATA_W-1:0] dout [NUM_CH];
  logic              sel_ok;
  logic              drop_q, drop_d;

  assign sel_ok   = {1'b0, bus.in_sel} < (SEL_W+1)'(NUM_CH);
  assign full_pad = NSEL'(full_v);
  assign bus.in_ready   = ~full_pad[bus.in_sel];
  assign bus.out_valid  = valid_v;
  assign bus.ch_full    = full_v;
  assign bus.drop_pulse = drop_q;
  assign drop_d = bus.in_valid & ~sel_ok;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign push_v[k] = bus.in_valid & bus.in_ready
                     & (bus.in_sel == SEL_W'(k));
    ch_fifo #(
      .DW(DATA_W),
      .DP(DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push_v[k]),
      .pop_i  (bus.out_ready[k]),
      .data_i (bus.in_data),
      .data_o (dout[k]),
      .valid_o(valid_v[k]),
      .full_o (full_v[k])
    );
  end

  // Pack channel heads onto the flat output bus.
  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      bus.out_data[k*DATA_W +: DATA_W] = dout[k];
  end

  // Registered one-cycle drop indication.
  always_ff @(posedge clk) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= drop_d;
  end

endmodule

// File: tb/tb_demux_channel_buffer.sv
// Scoreboard bench: queue-per-channel model checked every cycle.
// A second 6-channel build exercises dropped selects.
module tb_demux_channel_buffer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  int   vec = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  demux_channel_buffer_if #(.DW(8), .NC(8), .SW(3)) b8 ();
  demux_channel_buffer_if #(.DW(8), .NC(6), .SW(3)) b6 ();

  demux_channel_buffer #(
    .DATA_W(8), .NUM_CH(8), .SEL_W(3), .DEPTH(DEPTH)
  ) u8 (.clk(clk), .rst(rst), .bus(b8));

  demux_channel_buffer #(
    .DATA_W(8), .NUM_CH(6), .SEL_W(3), .DEPTH(DEPTH)
  ) u6 (.clk(clk), .rst(rst), .bus(b6));

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one byte queue per channel.
  logic [7:0] q [8][$];
  logic       drop_exp = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_rdy;
      int   s;
      s = int'(b8.in_sel);
      exp_rdy = (q[s].size() < DEPTH);
      chk("in_ready", b8.in_ready, exp_rdy);
      chk("drop8", b8.drop_pulse, drop_exp);
      drop_exp = 1'b0;
      for (int k = 0; k < 8; k++) begin
        logic [7:0] hd;
        hd = (q[k].size() != 0) ? q[k][0] : 8'h00;
        chk($sformatf("valid%0d", k), b8.out_valid[k], q[k].size() != 0);
        chk($sformatf("full%0d", k), b8.ch_full[k], q[k].size() == DEPTH);
        chk($sformatf("data%0d", k), b8.out_data[k*8 +: 8], hd);
        if (q[k].size() != 0 && b8.out_ready[k]) void'(q[k].pop_front());
      end
      if (b8.in_valid && exp_rdy) q[s].push_back(b8.in_data);
      if (rst) for (int k = 0; k < 8; k++) q[k].delete();
    end
  end

  task automatic cyc(input logic v, input int sel, input logic [7:0] d,
                     input logic [7:0] rdy);
    b8.in_valid  = v;
    b8.in_sel    = 3'(sel);
    b8.in_data   = d;
    b8.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc6(input logic v, input int sel, input logic [7:0] d);
    b6.in_valid = v;
    b6.in_sel   = 3'(sel);
    b6.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    b8.in_valid = 0; b8.in_sel = 0; b8.in_data = 0; b8.out_ready = 0;
    b6.in_valid = 0; b6.in_sel = 0; b6.in_data = 0; b6.out_ready = 0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    chk("idle_valid", b8.out_valid, 8'h00);
    chk("idle_full", b8.ch_full, 8'h00);

    // Sweep every select with the same byte.
    for (int s = 0; s < 8; s++) cyc(1, s, 8'hAA, 8'h00);
    b8.in_valid = 0;
    chk("sweep_valid", b8.out_valid, 8'hFF);
    chk("sweep_data", b8.out_data, {8{8'hAA}});

    // Reset with traffic buffered.
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    chk("rst_valid", b8.out_valid, 8'h00);

    // Fill channel 3, then probe ready on 3 and 5.
    cyc(1, 3, 8'h11, 0);
    cyc(1, 3, 8'h22, 0);
    cyc(1, 3, 8'h33, 0);
    cyc(1, 3, 8'h44, 0);
    chk("full3", b8.ch_full[3], 1'b1);
    b8.in_valid = 1; b8.in_sel = 3; b8.in_data = 8'h55;
    b8.out_ready = 8'h08;
    #1;
    chk("rdy_sel3", b8.in_ready, 1'b0);
    b8.in_sel = 5;
    #1;
    chk("rdy_sel5", b8.in_ready, 1'b1);
    b8.in_sel = 3;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h08);
    chk("drained3", b8.out_valid[3], 1'b0);

    // Channel 6: push and pop in one cycle at count 2.
    cyc(1, 6, 8'hA1, 0);
    cyc(1, 6, 8'hA2, 0);
    cyc(1, 6, 8'h55, 8'h40);
    chk("c6_head", b8.out_data[6*8 +: 8], 8'hA2);
    chk("c6_nf", b8.ch_full[6], 1'b0);
    cyc(0, 0, 0, 8'h40);
    chk("c6_head2", b8.out_data[6*8 +: 8], 8'h55);
    cyc(0, 0, 0, 8'h40);
    chk("c6_empty", b8.out_valid[6], 1'b0);

    // Random traffic biased to channel 0, reset once mid-run.
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
      rst = (i == 300);
      cyc($urandom_range(0, 3) != 0, sel, 8'($urandom),
          8'($urandom) & {7'h7F, 1'($urandom_range(0, 2) == 0)});
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 8'hFF);
    chk("final_empty", b8.out_valid, 8'h00);

    // Six-channel build: selects 6 and 7 are dropped.
    b6.in_valid = 1; b6.in_sel = 7; b6.in_data = 8'h99;
    #1;
    chk("d6_rdy7", b6.in_ready, 1'b1);
    @(posedge clk);
    #1;
    b6.in_valid = 0;
    chk("d6_drop7", b6.drop_pulse, 1'b1);
    chk("d6_nov7", b6.out_valid, 6'h00);
    cyc6(0, 0, 0);
    chk("d6_pulse_end", b6.drop_pulse, 1'b0);
    cyc6(1, 6, 8'h77);
    chk("d6_drop6", b6.drop_pulse, 1'b1);
    chk("d6_nov6", b6.out_valid, 6'h00);
    cyc6(1, 2, 8'h3C);
    chk("d6_nodrop", b6.drop_pulse, 1'b0);
    chk("d6_v2", b6.out_valid, 6'h04);
    chk("d6_d2", b6.out_data[2*8 +: 8], 8'h3C);
    b6.in_valid = 0;

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
